spi_mem_master_arb: RTL and testbench
=====================================

Name: spi_mem_master_arb

Overview:
- Two-requester SPI master that sequences 60-bit frames (12-bit header + 48-bit data) into the 10-bit-address, 48-bit-data SPI register memory slave.
- Frame is MSB-first: header {RW, 1'b0, ADDR[9:0]}, then 48 data bits. RW=1 means write.
- Arbitrates two local requesters round-robin and generates SCLK/CS_N/MOSI in all four CPOL/CPHA modes.
- Captures MISO read data and returns a one-cycle response per request.
- Sits between the register-access clients and the SPI pins, in the same clk domain as the slave.

Parameters:
- ADDR_BITS, 10, address width.
- DATA_BITS, 48, data width.
- HDR_BITS, 12, header width.
- CLK_DIV, 4, clk cycles per SCLK half-period. Must be ≥4 to cover the slave's 2-flop sync plus registered MISO.
- CS_GAP, 4, minimum clk cycles CS_N stays high between frames. Must be ≥4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpol  in  1  SCLK idle level; sampled at grant
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at grant
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  one-cycle pulse: request 0 accepted, fields captured
- req0_rw  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_BITS  target address
- req0_wdata  in  DATA_BITS  write data
- rsp0_valid  out  1  one-cycle pulse: request 0 complete
- rsp0_rdata  out  DATA_BITS  read data; 0 for writes; held until the next rsp0_valid
- req1_* / rsp1_*  same set as requester 0
- sclk  out  1  SPI clock
- cs_n  out  1  chip select, active low
- mosi  out  1  master out
- miso  in  1  slave out; sampled directly, same clk domain
- busy  out  1  high from grant until the end of the CS_GAP period

Behaviour:
- Reset (synchronous, rst=1): state IDLE, cs_n=1, sclk=0, mosi=0, all ready/rsp_valid=0, rdata=0, busy=0, rr pointer favours req0.
- Reset mid-frame: next clk edge forces cs_n=1 and sclk=0. The in-flight request is dropped with no rsp. The slave sees an incomplete frame and commits nothing.
- States: IDLE → SETUP → XFER → HOLD → GAP → IDLE.
- IDLE:
  - sclk follows live cpol.
  - If any valid, grant one and pulse its ready in the same cycle (cycle T).
  - Latch rw, addr, wdata, cpol, cpha and the frame shift register {rw, 0, addr, wr ? wdata : 0}.
- Arbitration:
  - Single valid: grant it.
  - Both valid: grant the one not granted last; pointer updates on every grant.
  - No grant while busy.
- SETUP (T+1 .. T+CLK_DIV):
  - cs_n=0.
  - cpha=0: mosi = frame bit 59 from T+1.
- XFER:
  - Half-period counter; SCLK toggles every CLK_DIV cycles.
  - Edge e = 0..119, edge e at cycle T+1+CLK_DIV·(e+1). Even e = leading, odd e = trailing.
  - cpha=0: bit k is driven at SETUP entry (k=0) or at trailing edge 2k−1; MISO is sampled at leading edge 2k.
  - cpha=1: bit k is driven at leading edge 2k; MISO is sampled at trailing edge 2k+1.
  - mosi is 0 for data bits of a read.
  - MISO samples for bits 12..59 shift MSB-first into rdata. Header-phase samples are ignored.
- HOLD: CLK_DIV cycles with sclk at cpol and cs_n=0, so the slave counts all 48 bits before CS rises.
- GAP entry, cycle T+1+121·CLK_DIV (T+485 at default):
  - cs_n=1.
  - rspX_valid pulses for the granted requester, with rdata.
- GAP: CS_GAP cycles; then IDLE.
- Next grant is no earlier than rsp cycle + CS_GAP, giving the slave a guaranteed cs rise and fall.
- ready and rsp for the same requester never coincide.
- cpol/cpha changes mid-frame have no effect until the next grant.

Decomposition:
- Package spi_mem_pkg holds:
  - ADDR_BITS, DATA_BITS, HDR_BITS.
  - FRAME_BITS=60, EDGES=120, RW_WRITE=1'b1.
  - State enum (IDLE, SETUP, XFER, HOLD, GAP).
  - Header-build function {rw, 1'b0, addr}.
- Sub-module spi_rr_arbiter: 2-way round-robin, taking valid[1:0] and enable and producing a one-hot grant and the pointer update.

Test Plan:
- Mode 0: req0 writes addr 0x155, data 0xA5A5_1234_5678 → slave dbg_wr_pulse with matching addr/data, dbg_wr_done=1; rsp0_valid exactly 485 clk after req0_ready; rsp0_rdata=0.
- Mode 3: req1 reads 0x155 → rsp1_rdata=0xA5A5_1234_5678; cs_n low for exactly 484 cycles.
- Modes 1 and 2:
  - Write 0x000←0xFFFF_FFFF_FFFF and 0x3FF←0xAAAA_5555_AAAA, then read both back → exact match.
  - sclk idles at cpol whenever cs_n=1.
- req0 and req1 both valid for 4 back-to-back requests → grant order 0,1,0,1; cs_n high ≥4 cycles between frames; busy stays high across GAP.
- rst=1 at edge 30 of a write of 0x0F0←0x1 (0x0F0 previously 0x2) → cs_n=1 and sclk=0 next cycle; no rsp, no dbg_wr_pulse; a later read of 0x0F0 returns 0x2.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared widths, frame geometry, FSM states and request layout for the SPI
// register-memory master.
package spi_mem_pkg;

    localparam int   ADDR_BITS  = 10;
    localparam int   DATA_BITS  = 48;
    localparam int   HDR_BITS   = 12;
    localparam int   FRAME_BITS = HDR_BITS + DATA_BITS;
    localparam int   EDGES      = 2 * FRAME_BITS;
    localparam logic RW_WRITE   = 1'b1;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    typedef struct packed {
        logic                 rw;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } req_t;

    function automatic logic [HDR_BITS-1:0] build_hdr(input logic rw,
                                                      input logic [ADDR_BITS-1:0] addr);
        return {rw, 1'b0, addr};
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// moves on every grant.
module spi_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       ptr_nxt
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign ptr_nxt = grant[1];

    // Reset value 1 makes requester 0 win the first contested grant.
    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (|grant)
            last_q <= ptr_nxt;
    end

endmodule

// File: rtl/spi_mem_master_arb.sv
// Two-requester SPI master: arbitrates, shifts a 60-bit frame out in any
// CPOL/CPHA mode, captures read data and returns one response per request.
module spi_mem_master_arb
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_rw,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [DATA_BITS-1:0] req0_wdata,
    output logic                 rsp0_valid,
    output logic [DATA_BITS-1:0] rsp0_rdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_rw,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [DATA_BITS-1:0] req1_wdata,
    output logic                 rsp1_valid,
    output logic [DATA_BITS-1:0] rsp1_rdata,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 busy
);

    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int EDGE_W  = $clog2(EDGES + 1);

    req_t [1:0]                 req;
    req_t                       sel;
    logic [1:0]                 req_valid, grant;
    logic                       owner_nxt, arb_en;
    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [EDGE_W-1:0]          edge_q, edge_idx;
    logic                       fire, drive, sample;
    logic                       owner_q, rw_q, cpol_q, cpha_q;
    logic [FRAME_BITS-1:0]      frame, shreg_q;
    logic [DATA_BITS-1:0]       rx_q;
    logic [1:0]                 rsp_valid_q;
    logic [1:0][DATA_BITS-1:0]  rdata_q;
    logic                       sclk_q, cs_n_q, mosi_q, busy_q;

    assign req[0]    = '{rw: req0_rw, addr: req0_addr, wdata: req0_wdata};
    assign req[1]    = '{rw: req1_rw, addr: req1_addr, wdata: req1_wdata};
    assign req_valid = {req1_valid, req0_valid};
    assign arb_en    = (state_q == IDLE) && !rst;
    assign sel       = req[owner_nxt];
    assign frame     = {build_hdr(sel.rw, sel.addr),
                        (sel.rw == RW_WRITE) ? sel.wdata : {DATA_BITS{1'b0}}};

    spi_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .enable  (arb_en),
        .grant   (grant),
        .ptr_nxt (owner_nxt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        fire     = 1'b0;
        edge_idx = edge_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|grant) state_d = SETUP;
            end
            SETUP: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                fire     = 1'b1;
                edge_idx = '0;
                cnt_d    = '0;
                state_d  = XFER;
            end
            XFER: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                fire  = 1'b1;
                cnt_d = '0;
                if (edge_q == EDGE_W'(EDGES - 1)) state_d = HOLD;
            end
            HOLD: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Even edges lead, odd edges trail; cpha picks which one drives and which samples.
    assign drive  = fire && (edge_idx[0] != cpha_q);
    assign sample = fire && (edge_idx[0] == cpha_q) && (edge_idx >= EDGE_W'(2 * HDR_BITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            edge_q      <= '0;
            owner_q     <= 1'b0;
            rw_q        <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            shreg_q     <= '0;
            rx_q        <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= '0;
            if (fire) begin
                edge_q <= edge_idx + 1'b1;
                sclk_q <= ~sclk_q;
            end
            if (drive) begin
                mosi_q  <= shreg_q[FRAME_BITS-1];
                shreg_q <= shreg_q << 1;
            end
            if (sample) rx_q <= {rx_q[DATA_BITS-2:0], miso};
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    if (|grant) begin
                        owner_q <= owner_nxt;
                        rw_q    <= sel.rw;
                        cpol_q  <= cpol;
                        cpha_q  <= cpha;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        rx_q    <= '0;
                        // cpha=0 presents bit 59 while CS settles; cpha=1 waits for edge 0.
                        shreg_q <= cpha ? frame : (frame << 1);
                        mosi_q  <= cpha ? 1'b0 : frame[FRAME_BITS-1];
                    end
                end
                HOLD: if (state_d == GAP) begin
                    cs_n_q               <= 1'b1;
                    mosi_q               <= 1'b0;
                    sclk_q               <= cpol_q;
                    rsp_valid_q[owner_q] <= 1'b1;
                    rdata_q[owner_q]     <= (rw_q == RW_WRITE) ? {DATA_BITS{1'b0}} : rx_q;
                end
                GAP: if (state_d == IDLE) busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_rdata = rdata_q[0];
    assign rsp1_rdata = rdata_q[1];
    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign mosi       = mosi_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_mem_master_arb.sv
// Scoreboard bench for spi_mem_master_arb with a behavioural register-memory
// slave on the SPI pins.
module tb_spi_mem_master_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpol, cpha;
    logic        req0_valid, req0_ready, req0_rw, rsp0_valid;
    logic [9:0]  req0_addr;
    logic [47:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_ready, req1_rw, rsp1_valid;
    logic [9:0]  req1_addr;
    logic [47:0] req1_wdata, rsp1_rdata;
    logic        sclk, cs_n, mosi, busy;
    logic        miso = 1'b0;

    typedef struct {
        int          id;
        logic [47:0] rdata;
        int          cyc;
    } sb_t;

    sb_t   sb_q[$];
    int    ordq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    in_abort = 1'b0;

    // slave model state
    logic [47:0] mem [0:1023];
    int          s_cnt = 0;
    logic [59:0] s_rx;
    logic [47:0] s_tx;
    logic        s_rw;
    logic [9:0]  s_addr;
    logic        s_cs_prev = 1'b1, s_sclk_prev = 1'b0;
    int          wr_count = 0;
    logic [9:0]  wr_addr;
    logic [47:0] wr_data;

    spi_mem_master_arb dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: reacts to SCLK edges while CS is low; commits writes only on a full frame.
    always @(negedge clk) begin : slave
        int e, k;
        if (cs_n) begin
            if (!s_cs_prev && s_cnt == 120 && s_rw) begin
                mem[s_addr] = s_rx[47:0];
                wr_count++;
                wr_addr = s_addr;
                wr_data = s_rx[47:0];
            end
            s_cnt = 0;
            s_rx  = '0;
            miso  = 1'b0;
        end else if (sclk != s_sclk_prev) begin
            e = s_cnt;
            if ((e % 2) == int'(cpha)) begin
                s_rx = {s_rx[58:0], mosi};
                if (e / 2 == 11) begin
                    s_rw   = s_rx[11];
                    s_addr = s_rx[9:0];
                    s_tx   = s_rw ? 48'h0 : mem[s_addr];
                end
            end else begin
                k = cpha ? e / 2 : (e + 1) / 2;
                if (k >= 12 && k < 60) miso = s_tx[59 - k];
            end
            s_cnt++;
        end
        s_cs_prev   = cs_n;
        s_sclk_prev = sclk;
    end

    // Monitor: pops the scoreboard on every response and watches pin-level rules.
    int fall_cyc = 0, rise_cyc = 0, busy_win = 0;
    logic m_cs_prev = 1'b1;
    always @(negedge clk) begin
        sb_t  e;
        logic id;
        if (busy_win > 0) begin
            chk("busy_in_gap", busy, 1'b1);
            busy_win--;
        end
        if (!rst && (rsp0_valid || rsp1_valid)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp0=%0b rsp1=%0b expected none", rsp0_valid, rsp1_valid);
            end else begin
                e  = sb_q.pop_front();
                id = rsp1_valid;
                chk("rsp_id", 64'(id), 64'(e.id));
                chk("rsp_rdata", id ? rsp1_rdata : rsp0_rdata, e.rdata);
                chk("rsp_latency", 64'(cyc - e.cyc), 64'd485);
                chk("rsp_not_with_ready", (req0_ready & rsp0_valid) | (req1_ready & rsp1_valid), 1'b0);
                chk("busy_at_rsp", busy, 1'b1);
                busy_win = 3;
            end
        end
        if (cs_n && busy) chk("sclk_idle_in_gap", sclk, cpol);
        if (m_cs_prev && !cs_n) begin
            chk("cs_high_gap_ge4", 64'(cyc - rise_cyc >= 4), 64'd1);
            fall_cyc = cyc;
        end
        if (!m_cs_prev && cs_n) begin
            if (!in_abort) chk("cs_low_len", 64'(cyc - fall_cyc), 64'd484);
            rise_cyc = cyc;
        end
        m_cs_prev = cs_n;
    end

    task automatic set_req(input int id, input logic v, input logic rw,
                           input logic [9:0] a, input logic [47:0] wd);
        if (id == 0) begin
            req0_valid = v; req0_rw = rw; req0_addr = a; req0_wdata = wd;
        end else begin
            req1_valid = v; req1_rw = rw; req1_addr = a; req1_wdata = wd;
        end
    endtask

    task automatic issue(input int id, input logic rw, input logic [9:0] a,
                         input logic [47:0] wd, input logic [47:0] exp, input bit track);
        sb_t e;
        bit  got = 1'b0;
        @(negedge clk);
        set_req(id, 1'b1, rw, a, wd);
        for (int i = 0; i < 3000 && !got; i++) begin
            #2;
            if ((id == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                ordq.push_back(id);
                if (track) begin
                    e.id = id; e.rdata = exp; e.cyc = cyc;
                    sb_q.push_back(e);
                end
            end
            @(negedge clk);
        end
        set_req(id, 1'b0, 1'b0, 10'h0, 48'h0);
        if (!got) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: requester %0d got no ready, expected one", id);
        end
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_done_timeout: pending=%0d expected 0", sb_q.size());
        end
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        @(negedge clk);
        cpol = pol;
        cpha = pha;
        repeat (2) @(negedge clk);
        chk("sclk_idle_level", sclk, pol);
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 1024; i++) mem[i] = 48'h0;
        rst = 1'b1; cpol = 1'b0; cpha = 1'b0;
        set_req(0, 1'b1, 1'b1, 10'h3, 48'h1);
        set_req(1, 1'b0, 1'b0, 10'h0, 48'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_no_ready", req0_ready, 1'b0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("rst_rdata0", rsp0_rdata, 48'h0);
        chk("rst_rdata1", rsp1_rdata, 48'h0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 10'h0, 48'h0);
        rst = 1'b0;

        // mode 0 write, then mode 3 read-back
        set_mode(1'b0, 1'b0);
        issue(0, 1'b1, 10'h155, 48'hA5A5_1234_5678, 48'h0, 1'b1);
        wait_done();
        chk("slave_wr_count_1", wr_count, 1);
        chk("slave_wr_addr", wr_addr, 10'h155);
        chk("slave_wr_data", wr_data, 48'hA5A5_1234_5678);
        set_mode(1'b1, 1'b1);
        issue(1, 1'b0, 10'h155, 48'h0, 48'hA5A5_1234_5678, 1'b1);
        wait_done();

        // boundary addresses: write in mode 1, read back in mode 2
        set_mode(1'b0, 1'b1);
        issue(0, 1'b1, 10'h000, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b1);
        wait_done();
        issue(1, 1'b1, 10'h3FF, 48'hAAAA_5555_AAAA, 48'h0, 1'b1);
        wait_done();
        set_mode(1'b1, 1'b0);
        issue(0, 1'b0, 10'h000, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b1);
        wait_done();
        issue(1, 1'b0, 10'h3FF, 48'h0, 48'hAAAA_5555_AAAA, 1'b1);
        wait_done();
        chk("slave_wr_count_3", wr_count, 3);

        // both requesters contending, two requests each
        set_mode(1'b0, 1'b0);
        ordq.delete();
        fork
            begin
                issue(0, 1'b1, 10'h0F0, 48'h2, 48'h0, 1'b1);
                issue(0, 1'b0, 10'h155, 48'h0, 48'hA5A5_1234_5678, 1'b1);
            end
            begin
                issue(1, 1'b0, 10'h000, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b1);
                issue(1, 1'b0, 10'h3FF, 48'h0, 48'hAAAA_5555_AAAA, 1'b1);
            end
        join
        wait_done();
        chk("grant_count", ordq.size(), 4);
        if (ordq.size() == 4) begin
            chk("grant_order_0", ordq[0], 0);
            chk("grant_order_1", ordq[1], 1);
            chk("grant_order_2", ordq[2], 0);
            chk("grant_order_3", ordq[3], 1);
        end
        chk("slave_wr_count_4", wr_count, 4);

        // reset in the middle of a write frame
        set_mode(1'b1, 1'b0);
        in_abort = 1'b1;
        issue(0, 1'b1, 10'h0F0, 48'h1, 48'h0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (s_cnt >= 31) hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL abort_edge_timeout: slave edges=%0d expected 31", s_cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cs_n", cs_n, 1'b1);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (600) @(posedge clk);
        chk("abort_no_commit", wr_count, 4);
        in_abort = 1'b0;
        issue(1, 1'b0, 10'h0F0, 48'h0, 48'h2, 1'b1);
        wait_done();
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
